// File: rtl/ex_muldiv_unit_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit.
// Also used by the ID decoder to map MULT/MULTU/DIV/DIVU onto op.
package ex_muldiv_unit_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } muldiv_state_e;

  function automatic int cnt_width(int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Pipeline <-> multiply/divide unit request and HI/LO write bundle.
// master: pipeline side, slave: the unit.
interface ex_muldiv_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  flush;
  logic                  start;
  logic [1:0]            op;
  logic [DATA_WIDTH-1:0] operand_1;
  logic [DATA_WIDTH-1:0] operand_2;
  logic                  busy;
  logic                  stall_req;
  logic                  done;
  logic                  hilo_write_en;
  logic [DATA_WIDTH-1:0] hi_write_data;
  logic [DATA_WIDTH-1:0] lo_write_data;

  modport master (
    output flush, start, op,
    output operand_1, operand_2,
    input  busy, stall_req, done,
    input  hilo_write_en,
    input  hi_write_data, lo_write_data
  );

  modport slave (
    input  flush, start, op,
    input  operand_1, operand_2,
    output busy, stall_req, done,
    output hilo_write_en,
    output hi_write_data, lo_write_data
  );
endinterface

// File: rtl/ex_muldiv_unit_div_core.sv
// Iterative radix-2 restoring divider on unsigned magnitudes.
// One quotient bit per step; last flags the final step.
module ex_muldiv_unit_div_core
  import ex_muldiv_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  load,
  input  logic                  step,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  last
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = cnt_width(W);

  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  den_q, den_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W:0]    part;
  logic [W:0]    diff;

  assign part = {rem_q, quo_q[W-1]};
  assign diff = part - {1'b0, den_q};

  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    den_d = den_q;
    cnt_d = cnt_q;
    if (clr) begin
      rem_d = '0;
      quo_d = '0;
      den_d = '0;
      cnt_d = '0;
    end else if (load) begin
      rem_d = '0;
      quo_d = dividend;
      den_d = divisor;
      cnt_d = CW'(W - 1);
    end else if (step) begin
      // Restore by keeping the shifted partial when it underflows.
      if (!diff[W]) begin
        rem_d = diff[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b1};
      end else begin
        rem_d = part[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b0};
      end
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      den_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      den_q <= den_d;
      cnt_q <= cnt_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign last      = (cnt_q == '0);

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multi-cycle MULT/MULTU/DIV/DIVU unit; sole HI/LO writer.
// Holds the FSM, sign handling, multiplier path and write pulse.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst,
  ex_muldiv_unit_if.slave bus
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = cnt_width(MUL_CYCLES);

  muldiv_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          msgn_q, msgn_d;
  logic          qneg_q, qneg_d;
  logic          rneg_q, rneg_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;

  logic          idle;
  logic          is_div;
  logic          sgn_in;
  logic          div0;
  logic [W-1:0]  a_mag;
  logic [W-1:0]  b_mag;
  logic [W-1:0]  mul_a;
  logic [W-1:0]  mul_b;
  logic          mul_s;
  logic [2*W-1:0] ext_a;
  logic [2*W-1:0] ext_b;
  logic [2*W-1:0] prod;
  logic [W-1:0]  quo;
  logic [W-1:0]  rem;
  logic          div_last;
  logic          div_load;
  logic          div_step;

  assign idle   = (state_q == ST_IDLE);
  assign is_div = bus.op[1];
  assign sgn_in = !bus.op[0];
  assign div0   = (bus.operand_2 == '0);

  assign a_mag = (sgn_in && bus.operand_1[W-1])
               ? (~bus.operand_1 + 1'b1) : bus.operand_1;
  assign b_mag = (sgn_in && bus.operand_2[W-1])
               ? (~bus.operand_2 + 1'b1) : bus.operand_2;

  // Single-cycle multiply reads the live operands at accept.
  assign mul_a = idle ? bus.operand_1 : a_q;
  assign mul_b = idle ? bus.operand_2 : b_q;
  assign mul_s = idle ? sgn_in : msgn_q;
  assign ext_a = {{W{mul_s & mul_a[W-1]}}, mul_a};
  assign ext_b = {{W{mul_s & mul_b[W-1]}}, mul_b};
  assign prod  = ext_a * ext_b;

  assign div_load = idle && bus.start && !bus.flush
                 && is_div && !div0;
  assign div_step = (state_q == ST_DIV);

  ex_muldiv_unit_div_core #(
    .DATA_WIDTH (W)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .clr       (bus.flush),
    .load      (div_load),
    .step      (div_step),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (quo),
    .remainder (rem),
    .last      (div_last)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    msgn_d  = msgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (bus.flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (bus.start) begin
          a_d    = bus.operand_1;
          b_d    = bus.operand_2;
          msgn_d = sgn_in;
          qneg_d = sgn_in & (bus.operand_1[W-1]
                           ^ bus.operand_2[W-1]);
          rneg_d = sgn_in & bus.operand_1[W-1];
          if (!is_div) begin
            if (MUL_CYCLES == 1) begin
              state_d      = ST_DONE;
              {hi_d, lo_d} = prod;
            end else begin
              state_d = ST_MUL;
              cnt_d   = CW'(MUL_CYCLES - 1);
            end
          end else if (div0) begin
            state_d = ST_DONE;
            hi_d    = bus.operand_1;
            lo_d    = '1;
          end else begin
            state_d = ST_DIV;
          end
        end
        ST_MUL: begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q <= CW'(1)) begin
            state_d      = ST_DONE;
            cnt_d        = '0;
            {hi_d, lo_d} = prod;
          end
        end
        ST_DIV: if (div_last) state_d = ST_FIX;
        ST_FIX: begin
          state_d = ST_DONE;
          lo_d = qneg_q ? (~quo + 1'b1) : quo;
          hi_d = rneg_q ? (~rem + 1'b1) : rem;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      msgn_q  <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      msgn_q  <= msgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy          = !idle;
  assign bus.stall_req     = (bus.start && idle)
                          || (state_q == ST_MUL)
                          || (state_q == ST_DIV)
                          || (state_q == ST_FIX);
  assign bus.done          = (state_q == ST_DONE);
  assign bus.hilo_write_en = bus.done && !bus.flush;
  assign bus.hi_write_data = hi_q;
  assign bus.lo_write_data = lo_q;

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Parametrised multi-cycle multiply/divide unit for the EX stage. It replaces the single-cycle multiplier and divider paths, and is the sole writer of HI/LO.
- Accepts one MULT/MULTU/DIV/DIVU operation at a time.
- Stalls the pipeline while the operation runs.
- Pulses a HI/LO write when the operation completes.
- Supports flush (abort) from the pipeline controller.

Parameters:
DATA_WIDTH, 32, operand and HI/LO width
MUL_CYCLES, 2, multiply latency in cycles from accept to done (min 1)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
flush  input  1  abort in-flight op; no HI/LO write
start  input  1  request new op (sampled only in IDLE)
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
operand_1  input  DATA_WIDTH  multiplicand / dividend
operand_2  input  DATA_WIDTH  multiplier / divisor
busy  output  1  state not IDLE
stall_req  output  1  hold ID/EX: start&IDLE, or state in {MUL,DIV,FIX}
done  output  1  one-cycle completion pulse
hilo_write_en  output  1  equals done & !flush
hi_write_data  output  DATA_WIDTH  product high half / remainder
lo_write_data  output  DATA_WIDTH  product low half / quotient

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - rst forces state IDLE.
  - rst clears busy, done, hilo_write_en, hi_write_data and lo_write_data to 0, plus all internal counters.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
- Accept:
  - In IDLE with start=1 at edge t, operands and op are latched.
  - start in any other state is ignored. The pipeline is stalled, so the request stays held.
- IDLE transitions:
  - MULT/MULTU: IDLE -> MUL. Counter loaded with MUL_CYCLES-1.
  - DIV/DIVU, divisor != 0: IDLE -> DIV. Counter loaded with DATA_WIDTH-1.
  - DIV/DIVU, divisor == 0: IDLE -> DONE directly.
- MUL:
  - Full 2*DATA_WIDTH product.
  - Signed for MULT (operands sign-extended), unsigned for MULTU.
  - Product may be pipelined across MUL_CYCLES registers.
  - Counter decrements; MUL -> DONE when counter==0.
- DIV:
  - Radix-2 restoring iteration on magnitudes, one quotient bit per cycle, DATA_WIDTH cycles.
  - For DIV, magnitudes come from two's-complement absolute values.
  - DIV -> FIX after the last bit.
- FIX (one cycle), sign correction for DIV:
  - Quotient negated if operand signs differ.
  - Remainder takes the sign of the dividend.
  - DIVU passes through unchanged.
  - FIX -> DONE.
- DONE:
  - done=1 for exactly one cycle; hi/lo_write_data are valid in this cycle.
  - DONE -> IDLE.
  - stall_req=0 in DONE, so the pipeline advances in the same cycle.
- Latency (done cycle relative to accept edge t):
  - MULT/MULTU: t+MUL_CYCLES.
  - DIV/DIVU: t+DATA_WIDTH+2.
  - Divide by zero: t+1.
- Boundary results:
  - Divide by zero: lo = all ones; hi = operand_1. Same for signed and unsigned.
  - Signed overflow, most-negative / -1: lo = most-negative, hi = 0.
  - Zero dividend: lo = 0, hi = 0.
- Flush:
  - Synchronous. Any state goes to IDLE on the next edge.
  - Counters cleared.
  - hilo_write_en is forced 0 in the flush cycle, including when state is DONE.
  - A start in the flush cycle is not accepted.
- Simultaneous events:
  - rst beats flush, which beats start.
  - Back-to-back ops: a new start is accepted in the IDLE cycle after DONE. Minimum spacing is therefore latency+1.
- Output hold: hi/lo_write_data keep their last result after DONE; they are only meaningful when done=1.

Decomposition:
- Shared header muldiv.v holds:
  - MULDIV_OP_* encodings (2-bit).
  - MULDIV_STATE_* encodings (3-bit).
  - Counter width macro, computed as clog2(DATA_WIDTH).
  - Shared with the ID decoder, which maps FUNCT_MULT/MULTU/DIV/DIVU to op.
- One sub-module, muldiv_div_core: iterative restoring divider.
  - Inputs: magnitudes, load, step.
  - Outputs: quotient, remainder, last.
- Top level keeps the FSM, sign handling, multiplier pipeline and write pulse.

Test Plan:
- MULT operand_1=0xFFFFFFFD (-3), operand_2=5 -> done at t+2; hi=0xFFFFFFFF, lo=0xFFFFFFF1; hilo_write_en one cycle; stall_req high at t, t+1 and low at t+2.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV 0xFFFFFFF9 (-7) by 2 -> done at t+34; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2.
- DIVU 100/0 -> done at t+1; lo=0xFFFFFFFF, hi=100. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV started, flush at t+10 -> busy=0 at t+11; no hilo_write_en ever. New MULT 3*4 started at t+11 -> lo=12, hi=0 at t+13.
- start held high throughout a DIV and released at DONE -> exactly one accept and one write; flush in the DONE cycle -> done may pulse but hilo_write_en=0.
